// File: rtl/disp_pkg.sv
// Shared types and constants for the two-digit multiplexed 7-segment scanner.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_GAP_B = 2'd0,
    ST_UNI   = 2'd1,
    ST_GAP_A = 2'd2,
    ST_DEC   = 2'd3
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_D0  = 7'h40;
  localparam logic [6:0] SEG_D1  = 7'h79;
  localparam logic [6:0] SEG_D2  = 7'h24;
  localparam logic [6:0] SEG_D3  = 7'h30;
  localparam logic [6:0] SEG_D4  = 7'h19;
  localparam logic [6:0] SEG_D5  = 7'h12;
  localparam logic [6:0] SEG_D6  = 7'h02;
  localparam logic [6:0] SEG_D7  = 7'h78;
  localparam logic [6:0] SEG_D8  = 7'h00;
  localparam logic [6:0] SEG_D9  = 7'h10;

endpackage

// File: rtl/seg7_bcd_decoder.sv
// BCD digit to active-low 7-segment pattern; non-BCD codes stay dark.
module seg7_bcd_decoder
  import disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    case (i_bcd)
      4'd0:    o_seg = SEG_D0;
      4'd1:    o_seg = SEG_D1;
      4'd2:    o_seg = SEG_D2;
      4'd3:    o_seg = SEG_D3;
      4'd4:    o_seg = SEG_D4;
      4'd5:    o_seg = SEG_D5;
      4'd6:    o_seg = SEG_D6;
      4'd7:    o_seg = SEG_D7;
      4'd8:    o_seg = SEG_D8;
      4'd9:    o_seg = SEG_D9;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scan_7seg.sv
// Two-digit multiplexed 7-segment scanner with blanking gaps and tear-free value commit.
//   state    | meaning
//   ST_GAP_B | all dark; pending value is committed on exit
//   ST_UNI   | units digit lit
//   ST_GAP_A | all dark between digits
//   ST_DEC   | tens digit lit (only when the value is 10..15)
module display_scan_7seg
  import disp_pkg::*;
#(
  parameter int DIGIT_CYCLES = 13500,
  parameter int GAP_CYCLES   = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] bin_i,
  input  logic       load_i,
  input  logic       blank_i,
  output logic [6:0] seg,
  output logic       uni,
  output logic       dec,
  output logic       upd_o
);

  localparam int MAX_CYC = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  // Counter holds remaining cycles minus one, so dwell-1 always fits in CW bits.
  localparam logic [CW-1:0] DIG_LD = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);

  scan_state_t   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_pend, r_disp;
  logic          r_upd;
  logic          w_commit;

  logic          w_tens;
  logic [3:0]    w_units;
  logic [3:0]    w_dig;
  logic [6:0]    w_seg_dec;
  logic          w_uni_on, w_dec_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_GAP_B;
      r_cnt   <= GAP_LD;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt - CW'(1);
    w_commit    = 1'b0;
    if (r_cnt == '0) begin
      case (r_state)
        ST_GAP_B: begin
          w_state_nxt = ST_UNI;
          w_cnt_nxt   = DIG_LD;
          w_commit    = 1'b1;
        end
        ST_UNI: begin
          w_state_nxt = ST_GAP_A;
          w_cnt_nxt   = GAP_LD;
        end
        ST_GAP_A: begin
          w_state_nxt = ST_DEC;
          w_cnt_nxt   = DIG_LD;
        end
        default: begin
          w_state_nxt = ST_GAP_B;
          w_cnt_nxt   = GAP_LD;
        end
      endcase
    end
  end

  // Capture is free-running; only the commit at GAP_B->UNI reaches the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 4'd0;
      r_disp <= 4'd0;
      r_upd  <= 1'b0;
    end else begin
      if (load_i) r_pend <= bin_i;
      r_upd <= w_commit && (r_pend != r_disp);
      if (w_commit) r_disp <= r_pend;
    end
  end

  assign w_tens  = (r_disp >= 4'd10);
  assign w_units = w_tens ? (r_disp - 4'd10) : r_disp;
  assign w_dig   = (r_state == ST_DEC) ? {3'b000, w_tens} : w_units;

  seg7_bcd_decoder u_dec (
    .i_bcd (w_dig),
    .o_seg (w_seg_dec)
  );

  assign w_uni_on = (r_state == ST_UNI) && !blank_i;
  assign w_dec_on = (r_state == ST_DEC) && w_tens && !blank_i;

  always_comb begin
    uni   = w_uni_on;
    dec   = w_dec_on;
    seg   = SEG_OFF;
    upd_o = r_upd;
    if (w_uni_on || w_dec_on) seg = w_seg_dec;
  end

endmodule

// File: doc/display_scan_7seg.md
DISPLAY_SCAN_7SEG -- requirements
Module: display_scan_7seg

Interface
REQ-001 Parameter DIGIT_CYCLES, default 13500: clock cycles each digit is lit (about 0.5 ms at 27 MHz); legal range >= 2.
REQ-002 Parameter GAP_CYCLES, default 27: blanking cycles between digits (anti-ghosting); legal range >= 1.
REQ-003 Port clk  in  1: single system clock; all state is updated on the rising edge.
REQ-004 Port rst_n  in  1: asynchronous, active-low reset; one clock, and reset is asynchronous and active-low.
REQ-005 Port bin_i  in  4: binary value 0..15, produced by the upstream Gray-to-binary converter.
REQ-006 Port load_i  in  1: strobe; bin_i is captured on any rising clk edge where load_i=1.
REQ-007 Port blank_i  in  1: 1 forces both digits dark; the scan keeps running.
REQ-008 Port seg  out  7: {g,f,e,d,c,b,a}, active-low; 0 lights a segment.
REQ-009 Port uni  out  1: units-digit transistor enable, active-high.
REQ-010 Port dec  out  1: tens-digit transistor enable, active-high.
REQ-011 Port upd_o  out  1: one-cycle pulse when a new value becomes the displayed value.

Function
REQ-012 Scan FSM states and dwell times:
- GAP_B: GAP_CYCLES cycles
- UNI: DIGIT_CYCLES cycles
- GAP_A: GAP_CYCLES cycles
- DEC: DIGIT_CYCLES cycles
REQ-013 State order: GAP_B -> UNI -> GAP_A -> DEC -> GAP_B; each state lasts exactly its dwell count, so the frame is 2*(DIGIT_CYCLES+GAP_CYCLES) cycles.
REQ-014 Dwell counter: a single down-counter, reloaded on every state change; width = clog2(max(DIGIT_CYCLES,GAP_CYCLES)).
REQ-015 Capture: pend_q <= bin_i on every edge with load_i=1; the last strobe wins; strobes in consecutive cycles are all legal.
REQ-016 Commit: disp_q <= pend_q only on the GAP_B->UNI transition, so a value never tears mid-frame; upd_o=1 in the first UNI cycle iff pend_q differed from the old disp_q.
REQ-017 Digit split: tens = (disp_q >= 10) ? 1 : 0; units = disp_q - 10*tens (4-bit, range 0..9).
REQ-018 Enables:
- uni=1 only in UNI
- dec=1 only in DEC, and only when tens=1 (leading-zero suppression)
- uni and dec are never both 1
- both are 0 in GAP_A/GAP_B
REQ-019 seg shows the units pattern in UNI and the tens pattern in DEC when that digit's enable is 1; otherwise seg = 7'h7F (all off).
REQ-020 blank_i=1 forces uni=0, dec=0, seg=7'h7F in the same cycle (combinational); FSM, counter and commit behaviour are unaffected.
REQ-021 Outputs are combinational decode of registered state (FSM, counter, disp_q, blank_i); no output depends combinationally on bin_i or load_i.
REQ-022 Digit patterns (seg, active-low): 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.

Reset
REQ-023 While rst_n=0, the block SHALL hold:
- state=GAP_B, counter loaded with GAP_CYCLES
- pend_q=0, disp_q=0
- uni=0, dec=0, seg=7'h7F, upd_o=0
REQ-024 Reset asserted mid-scan SHALL darken the display immediately; after release the first UNI is entered GAP_CYCLES cycles later and shows "0" with dec dark.

Structure
REQ-025 Package disp_pkg holds the scan-state enum, SEG_OFF (7'h7F) and the ten digit-pattern constants.
REQ-026 Sub-module seg7_bcd_decoder (4-bit BCD in, 7-bit active-low out; codes 10..15 -> SEG_OFF) is instantiated once, its input muxed between units and tens.

Verification (DIGIT_CYCLES=4, GAP_CYCLES=2)
REQ-027 Reset release with no load -> the following sequence, repeating with a 12-cycle frame:

| Cycles | uni | dec | seg |
|---|---|---|---|
| 2 | 0 | 0 | 7'h7F |
| 4 | 1 | 0 | 7'h40 |
| 6 | 0 | 0 | 7'h7F |

REQ-028 Load bin_i=13 during GAP_B -> next UNI: upd_o pulse, seg=7'h30 (3) with uni=1; then DEC: seg=7'h79 (1) with dec=1.
REQ-029 Load 7 during UNI, then load 12 during DEC of the same frame -> the displayed value changes only at the next GAP_B->UNI, to 12 (units 7'h24, tens 7'h79); 7 is never shown.
REQ-030 blank_i=1 for one full frame holding 15 -> uni=dec=0 and seg=7'h7F throughout; upd_o timing and the frame period are unchanged.
REQ-031 rst_n dropped in the third DEC cycle while showing 10 -> outputs go dark asynchronously; after release the display shows 0, not 10.
REQ-032 Random loads over 10k cycles -> assert uni&dec never 1, and every lit digit pattern matches the disp_q split.
